// File: rtl/clock_display_set.sv
// clock_display_set: settable HH:MM:SS wall clock with a three-state set-mode FSM
// and a four-digit multiplexed, active-low seven-segment driver.
//
// Ports:
//   clk          - system clock, rising edge
//   rst          - asynchronous active-high reset
//   btn_mode     - debounced single-cycle pulse, RUN -> SET_HR -> SET_MIN -> RUN
//   btn_inc      - debounced single-cycle pulse, increment selected field
//   btn_dec      - debounced single-cycle pulse, decrement selected field
//   segments     - a..g, active-low, registered
//   anode_active - active-low digit enables ([3]=hour tens .. [0]=min units), registered
//   dp           - active-low colon on digit 2, registered
//   setting      - high while in a set state, registered
module clock_display_set #(
  parameter int unsigned TICK_DIV    = 100_000_000,
  parameter int unsigned REFRESH_DIV = 25_000,
  parameter int unsigned HOUR_MODE   = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic [0:6] segments,
  output logic [3:0] anode_active,
  output logic       dp,
  output logic       setting
);

  localparam int unsigned PRE_W = $clog2(TICK_DIV);
  localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(TICK_DIV / 2);
  localparam logic [REF_W-1:0] REF_MAX  = REF_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_SET_HR,
    ST_SET_MIN
  } state_e;

  state_e           state_q, state_d;
  logic [4:0]       hr_q, hr_d;
  logic [5:0]       min_q, min_d;
  logic [5:0]       sec_q, sec_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [REF_W-1:0] ref_q, ref_d;
  logic [1:0]       scan_q, scan_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             dp_q, dp_d;
  logic             setting_q, setting_d;

  logic       tick;
  logic       blink;
  logic       inc_only;
  logic       dec_only;
  logic [4:0] hr_disp;
  logic [3:0] digit;

  // Active-low a..g pattern, a in bit 6.
  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 7'b0000001;
      4'd1:    seg_enc = 7'b1001111;
      4'd2:    seg_enc = 7'b0010010;
      4'd3:    seg_enc = 7'b0000110;
      4'd4:    seg_enc = 7'b1001100;
      4'd5:    seg_enc = 7'b0100100;
      4'd6:    seg_enc = 7'b0100000;
      4'd7:    seg_enc = 7'b0001111;
      4'd8:    seg_enc = 7'b0000000;
      4'd9:    seg_enc = 7'b0000100;
      default: seg_enc = 7'b1111111;
    endcase
  endfunction

  // Next-state: timekeeping, set FSM, display scan and registered outputs.
  always_comb begin
    state_d   = state_q;
    hr_d      = hr_q;
    min_d     = min_q;
    sec_d     = sec_q;
    pre_d     = pre_q;
    ref_d     = ref_q;
    scan_d    = scan_q;
    seg_d     = seg_q;
    an_d      = an_q;
    dp_d      = dp_q;
    setting_d = setting_q;
    hr_disp   = hr_q;
    digit     = 4'd0;

    tick     = (pre_q == PRE_MAX);
    blink    = (pre_q >= PRE_HALF);
    inc_only = btn_inc & ~btn_dec;
    dec_only = btn_dec & ~btn_inc;

    // Prescaler free-runs in every state; in set states it only drives blink.
    pre_d = tick ? '0 : pre_q + 1'b1;

    if (ref_q == REF_MAX) begin
      ref_d  = '0;
      scan_d = scan_q + 2'd1;
    end else begin
      ref_d = ref_q + 1'b1;
    end

    if (state_q == ST_RUN && tick) begin
      if (sec_q == 6'd59) begin
        sec_d = '0;
        if (min_q == 6'd59) begin
          min_d = '0;
          hr_d  = (hr_q == 5'd23) ? '0 : hr_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end

    // Mode wins over inc/dec in the same cycle.
    if (btn_mode) begin
      case (state_q)
        ST_RUN:    state_d = ST_SET_HR;
        ST_SET_HR: state_d = ST_SET_MIN;
        ST_SET_MIN: begin
          state_d = ST_RUN;
          sec_d   = '0;
          pre_d   = '0;
        end
        default:   state_d = ST_RUN;
      endcase
    end else begin
      case (state_q)
        ST_SET_HR: begin
          if (inc_only) hr_d = (hr_q == 5'd23) ? '0 : hr_q + 5'd1;
          if (dec_only) hr_d = (hr_q == 5'd0) ? 5'd23 : hr_q - 5'd1;
        end
        ST_SET_MIN: begin
          if (inc_only) min_d = (min_q == 6'd59) ? '0 : min_q + 6'd1;
          if (dec_only) min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
        end
        default: ;
      endcase
    end

    // 12-hour view folds 0..23 onto 12,1..11.
    if (HOUR_MODE == 12) begin
      hr_disp = (hr_q >= 5'd12) ? hr_q - 5'd12 : hr_q;
      if (hr_disp == 5'd0) hr_disp = 5'd12;
    end

    case (scan_q)
      2'd0:    digit = 4'(min_q % 6'd10);
      2'd1:    digit = 4'(min_q / 6'd10);
      2'd2:    digit = 4'(hr_disp % 5'd10);
      default: digit = 4'(hr_disp / 5'd10);
    endcase

    seg_d = seg_enc(digit);
    an_d  = ~(4'b0001 << scan_q);
    if (blink && ((state_q == ST_SET_HR && scan_q[1]) ||
                  (state_q == ST_SET_MIN && !scan_q[1]))) begin
      an_d = 4'b1111;
    end

    // Colon blinks with the second in RUN, steady while setting.
    dp_d      = ~((scan_q == 2'd2) && ((state_q != ST_RUN) || !blink));
    setting_d = (state_q != ST_RUN);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      hr_q      <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      pre_q     <= '0;
      ref_q     <= '0;
      scan_q    <= '0;
      seg_q     <= 7'b0000001;
      an_q      <= 4'b1110;
      dp_q      <= 1'b1;
      setting_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hr_q      <= hr_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      pre_q     <= pre_d;
      ref_q     <= ref_d;
      scan_q    <= scan_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      dp_q      <= dp_d;
      setting_q <= setting_d;
    end
  end

  assign segments     = seg_q;
  assign anode_active = an_q;
  assign dp           = dp_q;
  assign setting      = setting_q;

endmodule

// File: tb/tb_clock_display_set.sv
// tb_clock_display_set: two instances (24h/refresh 1 and 12h/refresh 3, both
// TICK_DIV=4) driven with the same buttons and checked every cycle against a
// seconds-of-day reference model, plus a table of set-mode vectors and
// hand-written rollover / exit / reset sequences.
module tb_clock_display_set;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic [0:6] seg_a, seg_b;
  logic [3:0] an_a, an_b;
  logic       dp_a, dp_b, set_a, set_b;

  clock_display_set #(.TICK_DIV(4), .REFRESH_DIV(1), .HOUR_MODE(24)) dut_a (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .segments(seg_a), .anode_active(an_a), .dp(dp_a), .setting(set_a));

  clock_display_set #(.TICK_DIV(4), .REFRESH_DIV(3), .HOUR_MODE(12)) dut_b (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .segments(seg_b), .anode_active(an_b), .dp(dp_b), .setting(set_b));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1);
  end

  localparam logic [12:0] RST_OUT = {7'b0000001, 4'b1110, 1'b1, 1'b0};

  int n_total = 0;
  int n_bad   = 0;

  // reference model: wall time, prescaler phase, per-instance scan, mode 0/1/2
  int m_hr, m_mn, m_sc, m_pre, m_st, m_scan_a, m_ref_b, m_scan_b;
  logic [12:0] exp_a, exp_b;

  typedef struct {
    bit m;
    bit i;
    bit d;
    int hr;
    int mn;
    bit set;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [6:0] enc7(input int d);
    case (d)
      0: enc7 = 7'b0000001;
      1: enc7 = 7'b1001111;
      2: enc7 = 7'b0010010;
      3: enc7 = 7'b0000110;
      4: enc7 = 7'b1001100;
      5: enc7 = 7'b0100100;
      6: enc7 = 7'b0100000;
      7: enc7 = 7'b0001111;
      8: enc7 = 7'b0000000;
      9: enc7 = 7'b0000100;
      default: enc7 = 7'b1111111;
    endcase
  endfunction

  function automatic int dec7(input logic [6:0] s);
    dec7 = 15;
    for (int k = 0; k < 10; k++) if (enc7(k) == s) dec7 = k;
  endfunction

  function automatic int hr12(input int h);
    hr12 = (h % 12 == 0) ? 12 : h % 12;
  endfunction

  function automatic logic [12:0] exp_out(input int hr, mn, pre, st, scan, bit twelve);
    int hd, dig;
    logic [3:0] an;
    logic d;
    hd = twelve ? hr12(hr) : hr;
    case (scan)
      0: dig = mn % 10;
      1: dig = mn / 10;
      2: dig = hd % 10;
      default: dig = hd / 10;
    endcase
    an = 4'b1111;
    an[scan] = 1'b0;
    if (st != 0 && pre >= 2 && ((st == 1 && scan >= 2) || (st == 2 && scan < 2))) an = 4'b1111;
    d = !(scan == 2 && (st != 0 || pre < 2));
    exp_out = {enc7(dig), an, d, st != 0};
  endfunction

  task automatic model_reset();
    m_hr = 0; m_mn = 0; m_sc = 0; m_pre = 0; m_st = 0;
    m_scan_a = 0; m_ref_b = 0; m_scan_b = 0;
    exp_a = RST_OUT; exp_b = RST_OUT;
  endtask

  task automatic model_step(input bit m, i, d);
    bit tick;
    int t;
    exp_a = exp_out(m_hr, m_mn, m_pre, m_st, m_scan_a, 1'b0);
    exp_b = exp_out(m_hr, m_mn, m_pre, m_st, m_scan_b, 1'b1);
    tick  = (m_pre == 3);
    m_pre = (m_pre + 1) % 4;
    if (m_st == 0 && tick) begin
      t = (m_hr * 3600 + m_mn * 60 + m_sc + 1) % 86400;
      m_hr = t / 3600; m_mn = (t / 60) % 60; m_sc = t % 60;
    end
    if (m) begin
      if (m_st == 2) begin m_sc = 0; m_pre = 0; end
      m_st = (m_st + 1) % 3;
    end else if (i != d && m_st != 0) begin
      if (m_st == 1) m_hr = (m_hr + (i ? 1 : 23)) % 24;
      else           m_mn = (m_mn + (i ? 1 : 59)) % 60;
    end
    m_scan_a = (m_scan_a + 1) % 4;
    m_ref_b++;
    if (m_ref_b == 3) begin m_ref_b = 0; m_scan_b = (m_scan_b + 1) % 4; end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s act=%h req=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // One clock: drive buttons, step model on the edge, compare #1 later.
  task automatic cycle(input bit m, i, d);
    btn_mode = m; btn_inc = i; btn_dec = d;
    @(posedge clk);
    model_step(m, i, d);
    #1;
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    check("out_a", 32'({seg_a, an_a, dp_a, set_a}), 32'(exp_a));
    check("out_b", 32'({seg_b, an_b, dp_b, set_b}), 32'(exp_b));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check("reset_a", 32'({seg_a, an_a, dp_a, set_a}), 32'(RST_OUT));
    check("reset_b", 32'({seg_b, an_b, dp_b, set_b}), 32'(RST_OUT));
  endtask

  // Reconstruct HH:MM from the 12-hour instance's lit digits.
  task automatic check_time(input string nm, input int hr, mn);
    int dig[4];
    int idx;
    bit ok;
    for (int k = 0; k < 4; k++) dig[k] = -1;
    ok = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin
      cycle(1'b0, 1'b0, 1'b0);
      case (an_b)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      if (idx >= 0) dig[idx] = dec7(seg_b);
      ok = (dig[0] >= 0) && (dig[1] >= 0) && (dig[2] >= 0) && (dig[3] >= 0);
    end
    if (!ok) begin
      n_total++; n_bad++;
      $display("FAIL %s_timeout act=digits_missing req=all_four", nm);
    end else begin
      check({nm, "_hr"}, 32'(dig[3] * 10 + dig[2]), 32'(hr12(hr)));
      check({nm, "_min"}, 32'(dig[1] * 10 + dig[0]), 32'(mn));
    end
  endtask

  initial begin
    // set-mode vectors from reset: {mode, inc, dec, hr, min, setting}
    vecs[0] = '{1, 0, 0,  0,  0, 1};
    vecs[1] = '{0, 0, 1, 23,  0, 1};
    vecs[2] = '{0, 1, 0,  0,  0, 1};
    vecs[3] = '{0, 1, 0,  1,  0, 1};
    vecs[4] = '{0, 1, 1,  1,  0, 1};
    vecs[5] = '{1, 0, 0,  1,  0, 1};
    vecs[6] = '{0, 0, 1,  1, 59, 1};
    vecs[7] = '{0, 1, 0,  1,  0, 1};
    vecs[8] = '{0, 0, 1,  1, 59, 1};
    vecs[9] = '{0, 1, 1,  1, 59, 1};

    model_reset();
    do_reset();

    // free run past the first hour: 14500 cycles = 01:00:25
    run(14500);
    check_time("freerun", 1, 0);

    // random buttons
    for (int k = 0; k < 3000; k++)
      cycle($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);

    // table of set-mode steps
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cycle(vecs[k].m, vecs[k].i, vecs[k].d);
      cycle(1'b0, 1'b0, 1'b0);
      check($sformatf("vec%0d_setting", k), 32'(set_a), 32'(vecs[k].set));
      check_time($sformatf("vec%0d", k), vecs[k].hr, vecs[k].mn);
    end

    // mode+inc in SET_MIN: back to RUN, min kept, seconds restart
    cycle(1'b1, 1'b1, 1'b0);
    check("exit_setting_hold", 32'(set_a), 32'd1);
    cycle(1'b0, 1'b0, 1'b0);
    check("exit_setting_low", 32'(set_a), 32'd0);
    check_time("exit", 1, 59);
    for (int k = 0; k < 250; k++) cycle(1'b0, k % 37 == 5, k % 53 == 7);
    check_time("after_exit", 2, 0);

    // 12h display of 23 and 13, then day rollover
    cycle(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1);
    check_time("hr23", 23, 0);
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 1'b1);
    check_time("hr13", 13, 0);
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check_time("set_2359", 23, 59);
    cycle(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 250; k++) cycle(1'b0, k % 41 == 3, k % 29 == 11);
    check_time("rollover", 0, 0);

    // asynchronous reset between edges in SET_HR
    cycle(1'b1, 1'b0, 1'b0);
    run(3);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_a", 32'({seg_a, an_a, dp_a, set_a}), 32'(RST_OUT));
    check("async_rst_b", 32'({seg_b, an_b, dp_b, set_b}), 32'(RST_OUT));
    model_reset();
    @(posedge clk); @(posedge clk);
    #1;
    check("rst_hold_a", 32'({seg_a, an_a, dp_a, set_a}), 32'(RST_OUT));
    rst = 1'b0;
    run(40);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_display_set.md
# clock_display_set

Settable HH:MM wall-clock with seconds timekeeping, a button-driven set-mode state machine and a four-digit multiplexed seven-segment driver. It sits between the board's debounced push-button pulses and the seven-segment display. It replaces the fixed MM:SS counter-plus-display with a block that is generalised in clock rate, refresh rate and 12/24-hour mode. Everything is synchronous to one clock; reset is asynchronous and active-high.

## Interface
- `TICK_DIV`, 100_000_000: clk cycles per second (≥4, even).
- `REFRESH_DIV`, 25_000: clk cycles each digit stays lit (≥1).
- `HOUR_MODE`, 24: 24 gives a 00–23 display; 12 gives a 12,01–11 display (no AM/PM).
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `btn_mode` input 1: single-cycle pulse, already debounced; advances the set FSM.
- `btn_inc` input 1: single-cycle pulse; increments the selected field.
- `btn_dec` input 1: single-cycle pulse; decrements the selected field.
- `segments` output [0:6]: a..g, active-low, registered.
- `anode_active` output [3:0]: active-low digit enables; [3]=hour tens, [2]=hour units, [1]=min tens, [0]=min units; registered.
- `dp` output 1: active-low decimal point, used as the colon on digit 2; registered.
- `setting` output 1: high in SET_HR or SET_MIN; registered.

## Operation
- **Internal state:** `hr` 0–23, `min` 0–59, `sec` 0–59, prescaler `pre` 0..TICK_DIV-1, refresh counter, 2-bit `scan`, FSM.
- **FSM states:** RUN, SET_HR, SET_MIN.
  - `btn_mode`: RUN→SET_HR→SET_MIN→RUN.
  - On SET_MIN→RUN, `sec` and `pre` clear to 0.
- **RUN:**
  - `pre` wraps at TICK_DIV-1 and issues a one-cycle tick.
  - The tick increments `sec`. At 59, `sec` wraps to 0 and `min` increments. At `min`=59, `min` wraps and `hr` increments. 23 wraps to 0.
  - `btn_inc` and `btn_dec` are ignored.
- **SET_HR / SET_MIN:**
  - `pre` keeps counting, for blink only. `sec`, `min` and `hr` do not advance from ticks.
  - `btn_inc` adds 1 to the selected field modulo its range (hr 24, min 60). `btn_dec` subtracts 1, also wrapping: 0→23 or 0→59.
- **Simultaneous buttons:**
  - `btn_inc` and `btn_dec` together: no change.
  - `btn_mode` with either: the mode transition wins and inc/dec is ignored that cycle.
- **HOUR_MODE=12:** the displayed hour is `hr` mod 12, with 0 shown as 12. Internal `hr` still counts 0–23.
- **Display:**
  - `scan` advances 0→1→2→3→0 every REFRESH_DIV cycles.
  - Exactly one anode is low, `anode_active[scan]`.
  - Segment encoding is standard active-low 0–9, e.g. 0=0000001, 1=1001111, 8=0000000.
- **Blink:** in set states, while `pre` ≥ TICK_DIV/2, the anodes of the selected field are forced high (blank). SET_HR blanks digits 3,2; SET_MIN blanks digits 1,0.
- **Colon (`dp`):**
  - Low only while `scan`=2.
  - In RUN, it is lit only while `pre` < TICK_DIV/2.
  - In set states, it is lit steadily.

## Timing
- **Reset values:**
  - hr=min=sec=0, pre=0, refresh=0, scan=0, FSM=RUN, setting=0.
  - anode_active=4'b1110, segments=0000001 (digit "0"), dp=1.
- All outputs are registered. They reflect the previous cycle's counters/FSM, giving 1-cycle latency.
- A button takes effect at the next edge. `setting` rises 1 cycle after the `btn_mode` pulse.
- The first RUN tick after reset occurs at cycle TICK_DIV, counted from reset release. The first tick after leaving SET_MIN occurs TICK_DIV cycles after the transition edge.
- Mid-operation `rst` immediately returns every register to its reset value, regardless of FSM state.

## Test plan
1. **Free-run rollover.** TICK_DIV=4, REFRESH_DIV=1, reset, run 4·60·60·24 cycles. Required: min increments every 240 cycles, hr every 14400 cycles, and 23:59:59→00:00:00 on the final tick.
2. **Setting hours.** Pulse mode, then dec once. Required: hr=23, display 2,3 on anodes 3,2, and the hour digits blank while pre≥2. Pulse inc twice. Required: hr=01.
3. **Exit set mode.** Set min to 59, then pulse mode. Required: FSM=RUN, setting=0 after 1 cycle, sec=0, and the next tick exactly 4 cycles later.
4. **Simultaneous buttons.** In SET_MIN, inc+dec in the same cycle. Required: min unchanged. Mode+inc in the same cycle. Required: returns to RUN, min unchanged.
5. **12-hour display.** HOUR_MODE=12 with hr=0, then hr=13. Required: digits show 1,2 and then 0,1. In RUN, inc/dec pulses leave the time unchanged.
6. **Async reset.** Assert rst mid-SET_HR, between edges. Required: outputs go immediately to 4'b1110 / 0000001 / dp=1 / setting=0.
